color_blob_tracker: RTL

Multi-channel colour-blob statistics engine fed by the `rgb2hsv` pixel stream inside the ball-detector top. For each of `CHANNELS` independently configured HSV windows it counts matching pixels and tracks their bounding box over one camera frame. It publishes a per-frame result set on every frame boundary. It generalises the single-hue detection path to N colours, wrap-around hue windows and per-frame bounding boxes, replacing the unused `pipette_center` path.

---
 rtl/color_blob_tracker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/color_blob_tracker.sv
// Per-frame colour-blob statistics: for each HSV window, counts matching pixels
// and tracks their bounding box, publishing the result set on every frame_start.
module color_blob_tracker #(
  parameter int CHANNELS = 2,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int MIN_PIX  = 16
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           pix_valid,
  input  logic [8:0]                     hue,
  input  logic                           hue_invalid,
  input  logic [4:0]                     saturation,
  input  logic [4:0]                     value,
  input  logic                           line_end,
  input  logic                           frame_start,
  input  logic [9*CHANNELS-1:0]          cfg_hue_lo,
  input  logic [9*CHANNELS-1:0]          cfg_hue_hi,
  input  logic [5*CHANNELS-1:0]          cfg_sat_min,
  input  logic [5*CHANNELS-1:0]          cfg_val_min,
  output logic [(XW+YW)*CHANNELS-1:0]    res_count,
  output logic [XW*CHANNELS-1:0]         res_xmin,
  output logic [XW*CHANNELS-1:0]         res_xmax,
  output logic [YW*CHANNELS-1:0]         res_ymin,
  output logic [YW*CHANNELS-1:0]         res_ymax,
  output logic [CHANNELS-1:0]            found,
  output logic                           result_valid,
  output logic [7:0]                     frame_cnt
);

  localparam int CW = XW + YW;

  // Config shadows, live config views and the effective config for this cycle
  logic [CHANNELS-1:0][8:0] hue_lo_q, hue_hi_q, cfg_lo_w, cfg_hi_w, lo_eff, hi_eff;
  logic [CHANNELS-1:0][4:0] sat_min_q, val_min_q, cfg_sat_w, cfg_val_w, sat_eff, val_eff;

  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;

  logic [CHANNELS-1:0]          match;
  logic [CHANNELS-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0][XW-1:0]  xmin_q, xmin_d, xmax_q, xmax_d;
  logic [CHANNELS-1:0][YW-1:0]  ymin_q, ymin_d, ymax_q, ymax_d;

  logic [CHANNELS-1:0][CW-1:0]  res_count_q;
  logic [CHANNELS-1:0][XW-1:0]  res_xmin_q, res_xmax_q;
  logic [CHANNELS-1:0][YW-1:0]  res_ymin_q, res_ymax_q;
  logic [CHANNELS-1:0]          found_q;
  logic                         result_valid_q;
  logic [7:0]                   frame_cnt_q;

  assign cfg_lo_w  = cfg_hue_lo;
  assign cfg_hi_w  = cfg_hue_hi;
  assign cfg_sat_w = cfg_sat_min;
  assign cfg_val_w = cfg_val_min;

  // A pixel coincident with frame_start belongs to the new frame, so it must
  // see the config being loaded on this edge rather than the old shadow.
  assign lo_eff  = frame_start ? cfg_lo_w  : hue_lo_q;
  assign hi_eff  = frame_start ? cfg_hi_w  : hue_hi_q;
  assign sat_eff = frame_start ? cfg_sat_w : sat_min_q;
  assign val_eff = frame_start ? cfg_val_w : val_min_q;

  always_ff @(posedge clk) begin
    if (res || frame_start) begin
      hue_lo_q  <= cfg_lo_w;
      hue_hi_q  <= cfg_hi_w;
      sat_min_q <= cfg_sat_w;
      val_min_q <= cfg_val_w;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    x_cur = frame_start ? '0 : x_q;
    y_cur = frame_start ? '0 : y_q;
    x_d   = x_cur;
    y_d   = y_cur;
    if (line_end) begin
      x_d = '0;
      if (y_cur != '1) y_d = y_cur + YW'(1);
    end else if (pix_valid && x_cur != '1) begin
      x_d = x_cur + XW'(1);
    end
  end

  always_comb begin
    logic hue_in;
    match = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (lo_eff[c] <= hi_eff[c]) hue_in = (hue >= lo_eff[c]) && (hue <= hi_eff[c]);
      else                        hue_in = (hue >= lo_eff[c]) || (hue <= hi_eff[c]);
      match[c] = pix_valid && !hue_invalid && (saturation >= sat_eff[c]) &&
                 (value >= val_eff[c]) && hue_in;
    end
  end

  // Working accumulators restart from the empty state at a frame boundary.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c]  = frame_start ? '0 : cnt_q[c];
      xmin_d[c] = frame_start ? '1 : xmin_q[c];
      xmax_d[c] = frame_start ? '0 : xmax_q[c];
      ymin_d[c] = frame_start ? '1 : ymin_q[c];
      ymax_d[c] = frame_start ? '0 : ymax_q[c];
      if (match[c]) begin
        if (cnt_d[c] != '1) cnt_d[c] = cnt_d[c] + CW'(1);
        if (x_cur < xmin_d[c]) xmin_d[c] = x_cur;
        if (x_cur > xmax_d[c]) xmax_d[c] = x_cur;
        if (y_cur < ymin_d[c]) ymin_d[c] = y_cur;
        if (y_cur > ymax_d[c]) ymax_d[c] = y_cur;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (res) begin
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      xmin_q <= '1;
      xmax_q <= '0;
      ymin_q <= '1;
      ymax_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      res_count_q    <= '0;
      res_xmin_q     <= '0;
      res_xmax_q     <= '0;
      res_ymin_q     <= '0;
      res_ymax_q     <= '0;
      found_q        <= '0;
      result_valid_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      result_valid_q <= frame_start;
      if (frame_start) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        for (int c = 0; c < CHANNELS; c++) begin
          res_count_q[c] <= cnt_q[c];
          found_q[c]     <= cnt_q[c] >= CW'(MIN_PIX);
          // An empty channel reports a zero box instead of the inverted sentinels.
          if (cnt_q[c] == '0) begin
            res_xmin_q[c] <= '0;
            res_xmax_q[c] <= '0;
            res_ymin_q[c] <= '0;
            res_ymax_q[c] <= '0;
          end else begin
            res_xmin_q[c] <= xmin_q[c];
            res_xmax_q[c] <= xmax_q[c];
            res_ymin_q[c] <= ymin_q[c];
            res_ymax_q[c] <= ymax_q[c];
          end
        end
      end
    end
  end

  assign res_count    = res_count_q;
  assign res_xmin     = res_xmin_q;
  assign res_xmax     = res_xmax_q;
  assign res_ymin     = res_ymin_q;
  assign res_ymax     = res_ymax_q;
  assign found        = found_q;
  assign result_valid = result_valid_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
